// File: rtl/uart_tx_engine_if.sv
// FWFT FIFO head handshake between a TX FIFO (master) and the UART TX engine (slave).
// The engine pops with a one-cycle o_fifo_rd_req and samples the head word in that cycle.
interface uart_tx_engine_if #(
  parameter int DW = 8
);
  logic          i_fifo_valid;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_parity_error;
  logic          o_fifo_rd_req;

  modport master (
    output i_fifo_valid,
    output i_fifo_data,
    output i_fifo_parity_error,
    input  o_fifo_rd_req
  );

  modport slave (
    input  i_fifo_valid,
    input  i_fifo_data,
    input  i_fifo_parity_error,
    output o_fifo_rd_req
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: pops one word from an FWFT FIFO and serialises it (start, 5-8 data, parity, 1-2 stop).
// Frame begins the cycle after the pop; the FIFO is only popped from IDLE, so it is held off for the whole frame.
module uart_tx_engine #(
  parameter int OVERSAMPLE = 16,
  parameter int DW         = 8
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_baud_tick,
  input  logic            i_tx_en,
  input  logic            i_parity_en,
  input  logic            i_parity_odd,
  input  logic            i_stop2,
  input  logic [1:0]      i_data_len,
  uart_tx_engine_if.slave fifo_if,
  output logic            o_txd,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_drop
);
  localparam int            CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    len_q, len_d;
  logic          par_en_q, par_en_d;
  logic          par_odd_q, par_odd_d;
  logic          stop2_q, stop2_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          arm_q, arm_d;
  logic          pop;
  logic          bit_end;
  logic          par_bit;
  logic [2:0]    last_idx;
  logic [7:0]    data_mask;

  assign bit_end   = i_baud_tick && (cnt_q == CNT_LAST);
  assign last_idx  = 3'd4 + {1'b0, len_q};
  assign data_mask = 8'hFF >> (2'd3 - len_q);
  assign par_bit   = (^(data_q & data_mask)) ^ par_odd_q;

  // arm_q is low for one cycle after every pop and after reset, which blocks a double pop
  // and any pop before the first clock edge out of reset.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    arm_d     = 1'b1;
    pop       = 1'b0;

    if (state_q != IDLE && i_baud_tick) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (i_tx_en && fifo_if.i_fifo_valid && arm_q) begin
          pop       = 1'b1;
          arm_d     = 1'b0;
          data_d    = fifo_if.i_fifo_data[DW-1 -: 8];
          len_d     = i_data_len;
          par_en_d  = i_parity_en;
          par_odd_d = i_parity_odd;
          stop2_d   = i_stop2;
          if (fifo_if.i_fifo_parity_error) begin
            drop_d = 1'b1;
          end else begin
            state_d = START;
            txd_d   = 1'b0;
          end
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          txd_d   = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == last_idx) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = par_bit;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = data_q[idx_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        // idx_q counts stop bits already completed
        if (bit_end) begin
          if (stop2_q && idx_q == 3'd0) begin
            idx_d = 3'd1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      len_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      len_q     <= len_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
      arm_q     <= arm_d;
    end
  end

  assign fifo_if.o_fifo_rd_req = pop;
  assign o_txd                 = txd_q;
  assign o_busy                = (state_q != IDLE);
  assign o_done                = done_q;
  assign o_drop                = drop_q;

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter OVERSAMPLE, default 16: i_baud_tick strobes per bit; legal 4..32.
REQ-002 Parameter DW, default 8: FIFO data width; the upper 8 bits are used.
REQ-003 i_clk  input  1  system clock; all logic on rising edge.
REQ-004 i_nrst  input  1  asynchronous active-low reset.
REQ-005 i_baud_tick  input  1  one-cycle oversample strobe.
REQ-006 i_tx_en  input  1  transmit enable; gates frame start only.
REQ-007 i_parity_en  input  1  parity bit enable.
REQ-008 i_parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-009 i_stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 i_data_len  input  2  data bits: 0=5, 1=6, 2=7, 3=8.
REQ-011 i_fifo_valid  input  1  FWFT FIFO head valid.
REQ-012 i_fifo_data  input  DW  FWFT FIFO head data.
REQ-013 i_fifo_parity_error  input  1  FIFO storage parity error on the head word.
REQ-014 o_fifo_rd_req  output  1  pop strobe to the FWFT FIFO.
REQ-015 o_txd  output  1  serial line; idle high.
REQ-016 o_busy  output  1  high in any state other than IDLE.
REQ-017 o_done  output  1  one-cycle pulse at the end of the last stop bit.
REQ-018 o_drop  output  1  one-cycle pulse when a word is discarded for a FIFO parity error.

Function
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY and STOP; the STOP state spans 1 or 2 stop bits.
REQ-020 In IDLE with i_tx_en=1 and i_fifo_valid=1, the block SHALL assert o_fifo_rd_req for exactly one cycle.
REQ-021 In that same cycle, the block SHALL sample i_fifo_data, i_parity_en, i_parity_odd, i_stop2 and i_data_len into shadow registers.
REQ-022 Config changes during a frame SHALL NOT affect that frame.
REQ-023 If i_fifo_parity_error=1 in the pop cycle, the block SHALL discard the word, pulse o_drop the next cycle and remain in IDLE.
REQ-024 In that case o_txd SHALL stay high.
REQ-025 Otherwise the FSM SHALL enter START the next cycle, and o_txd SHALL be driven from a register.
REQ-026 o_fifo_rd_req SHALL never be asserted outside IDLE.
REQ-027 o_fifo_rd_req SHALL never be asserted when i_fifo_valid=0.
REQ-028 o_fifo_rd_req SHALL be deasserted in the cycle after a pop, which prevents a double pop.
REQ-029 Bit timing: a tick counter of width $clog2(OVERSAMPLE) SHALL advance only on i_baud_tick.
REQ-030 Each bit SHALL last exactly OVERSAMPLE ticks.
REQ-031 The state or bit index SHALL advance on the tick where the counter equals OVERSAMPLE-1, and the counter SHALL then wrap to 0.
REQ-032 The tick counter SHALL be cleared on entry to START.
REQ-033 START SHALL drive o_txd=0.
REQ-034 DATA SHALL send the data bits LSB first: bit index 0 .. (5+len-1) is driven, and the unused upper bits are ignored.
REQ-035 PARITY is entered only if the latched parity enable is set, and drives XOR(data bits sent) XOR odd.
REQ-036 STOP SHALL drive o_txd=1 for 1 or 2 bit periods.
REQ-037 At the end of STOP, the block SHALL pulse o_done and return to IDLE.
REQ-038 Back-to-back frames: if the FIFO is valid and enabled, the next pop SHALL occur in the first IDLE cycle after o_done, with no idle bit inserted.
REQ-039 Deasserting i_tx_en mid-frame SHALL complete the current frame, and no further pop SHALL occur.
REQ-040 A bit width count of less than one whole tick is impossible; i_baud_tick held high SHALL advance once per clock.

Reset
REQ-041 On i_nrst=0, the outputs SHALL take these values immediately: o_txd=1, o_busy=0, o_fifo_rd_req=0, o_done=0, o_drop=0.
REQ-042 On i_nrst=0, the FSM SHALL go to IDLE, and the counters and shadow registers SHALL be cleared to 0.
REQ-043 A reset mid-frame SHALL abort the frame, and the popped word SHALL be lost with no o_done pulse.
REQ-044 After reset release, the first pop SHALL NOT occur before the first rising edge with i_nrst=1.

Verification
REQ-045 8N1, OVERSAMPLE=16, tick every cycle, FIFO holds 0xA5 -> one rd_req pulse; o_txd carries 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; o_done at cycle 160 after START entry.
REQ-046 7O2, data 0x41 -> bits 0,1,0,0,0,0,0,1,1,1,1 (the parity bit equals 1 because there is an even count of ones and odd parity is selected); 11 bit periods.
REQ-047 Head word has i_fifo_parity_error=1, then a clean 0x55 -> o_drop pulse with o_txd high throughout, then 0x55 framed normally; exactly 2 pops.
REQ-048 3 words queued, i_tx_en held -> three contiguous frames with no idle gap; i_tx_en dropped during frame 2 -> frame 2 completes, word 3 is not popped.
REQ-049 Config toggled mid-frame (len 3->0, parity on) -> the current frame uses the latched config; the next frame uses the new config.
REQ-050 i_nrst pulsed in DATA bit 3 -> o_txd=1 the same cycle, o_busy=0, no o_done; the next frame starts cleanly from the next FIFO word.
